// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC select and optional return-address stack.
// Define PC_RAS_EN to build the return-address stack; otherwise pop falls back to ra.
module pc_unit #(
  parameter int WIDTH = 16,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC = 0,
  parameter int STEP = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       pcSrc,
  input  logic             pcWrite,
  input  logic [WIDTH-1:0] immPlusPC,
  input  logic [WIDTH-1:0] immAddr,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] pcPlusMary,
  input  logic [WIDTH-1:0] jcmpImm,
  input  logic             rasPush,
  input  logic             rasClr,
  output logic [WIDTH-1:0] pcCur,
  output logic [WIDTH-1:0] pcPlus,
  output logic [WIDTH-1:0] rasTop,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasOvf,
  output logic             rasUnf
);
  logic [WIDTH-1:0] nextPc, popPc;
  assign pcPlus = pcCur + WIDTH'(STEP);
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] topPtr, upPtr;
  logic [CW-1:0] count;
  logic ovf, unf, push, pop;
  assign upPtr = topPtr + PW'(1);
  assign push = pcWrite && rasPush;
  assign pop = pcWrite && pcSrc == 3'd6;
  assign rasEmpty = count == '0;
  assign rasFull = count == CW'(RAS_DEPTH);
  assign rasTop = rasEmpty ? '0 : stack[topPtr];
  assign popPc = rasEmpty ? ra : rasTop;
  assign rasOvf = ovf;
  assign rasUnf = unf;
  // Circular buffer: a push when full advances over the oldest entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      topPtr <= '0;
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (rasClr) begin
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push && pop && !rasEmpty) begin
      stack[topPtr] <= pcPlus;
    end else if (push) begin
      stack[upPtr] <= pcPlus;
      topPtr <= upPtr;
      count <= rasFull ? count : count + CW'(1);
      if (rasFull) ovf <= 1'b1;
      if (pop) unf <= 1'b1;
    end else if (pop) begin
      if (rasEmpty) unf <= 1'b1;
      else begin
        topPtr <= topPtr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end
`else
  logic unusedRas;
  assign unusedRas = rasPush ^ rasClr;
  assign popPc = ra;
  assign rasTop = '0;
  assign rasEmpty = 1'b1;
  assign rasFull = 1'b0;
  assign rasOvf = 1'b0;
  assign rasUnf = 1'b0;
`endif
  always_comb begin
    nextPc = pcSrc == 3'd0 ? pcPlus :
             pcSrc == 3'd1 ? immPlusPC :
             pcSrc == 3'd2 ? immAddr :
             pcSrc == 3'd3 ? ra :
             pcSrc == 3'd4 ? pcPlusMary :
             pcSrc == 3'd5 ? jcmpImm :
             pcSrc == 3'd6 ? popPc : pcCur;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pcCur <= WIDTH'(RESET_PC);
    else if (pcWrite) pcCur <= nextPc;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven check of pc_unit next-PC selection and return-address stack.
module tb_pc_unit;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [2:0] pcSrc = '0;
  logic pcWrite = 1'b0, rasPush = 1'b0, rasClr = 1'b0;
  logic [15:0] immPlusPC = '0, immAddr = '0, ra = '0, pcPlusMary = '0, jcmpImm = '0;
  logic [15:0] pcCur, pcPlus, rasTop;
  logic rasEmpty, rasFull, rasOvf, rasUnf;
  int checks = 0, errors = 0;
  localparam logic [3:0] N = 4'b0000, E = 4'b1000;
  typedef struct {
    logic [2:0] src;
    logic wr, push, clr;
    logic [15:0] tgt, expPc, expTop;
    logic [3:0] expFl;
  } vec_t;
  vec_t vq[$];
  pc_unit dut (
    .clock(clock), .reset_n(reset_n), .pcSrc(pcSrc), .pcWrite(pcWrite),
    .immPlusPC(immPlusPC), .immAddr(immAddr), .ra(ra), .pcPlusMary(pcPlusMary),
    .jcmpImm(jcmpImm), .rasPush(rasPush), .rasClr(rasClr), .pcCur(pcCur),
    .pcPlus(pcPlus), .rasTop(rasTop), .rasEmpty(rasEmpty), .rasFull(rasFull),
    .rasOvf(rasOvf), .rasUnf(rasUnf)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chkAll(input string tag, input logic [15:0] ePc, input logic [15:0] eTop, input logic [3:0] eFl);
    chk({tag, ".pcCur"}, pcCur, ePc);
    chk({tag, ".pcPlus"}, pcPlus, ePc + 16'd2);
    chk({tag, ".rasTop"}, rasTop, eTop);
    chk({tag, ".flags"}, {12'd0, rasEmpty, rasFull, rasOvf, rasUnf}, {12'd0, eFl});
  endtask
  function automatic vec_t v(input logic [2:0] src, input logic wr, input logic push, input logic clr,
                             input logic [15:0] tgt, input logic [15:0] expPc, input logic [15:0] expTop,
                             input logic [3:0] expFl);
    vec_t x;
    x.src = src; x.wr = wr; x.push = push; x.clr = clr;
    x.tgt = tgt; x.expPc = expPc; x.expTop = expTop; x.expFl = expFl;
    return x;
  endfunction
  task automatic apply(input vec_t x);
    pcSrc = x.src; pcWrite = x.wr; rasPush = x.push; rasClr = x.clr; ra = x.tgt;
    immPlusPC = x.src == 3'd1 ? x.tgt : 16'h1111;
    immAddr = x.src == 3'd2 ? x.tgt : 16'h2222;
    pcPlusMary = x.src == 3'd4 ? x.tgt : 16'h4444;
    jcmpImm = x.src == 3'd5 ? x.tgt : 16'h5555;
    @(posedge clock);
    #1;
  endtask
  initial begin
    vq.push_back(v(2, 1, 0, 0, 16'd42, 16'd42, 0, E));
    vq.push_back(v(0, 1, 0, 0, 0, 16'd44, 0, E));
    vq.push_back(v(0, 1, 0, 0, 0, 16'd46, 0, E));
    vq.push_back(v(0, 1, 0, 0, 0, 16'd48, 0, E));
    vq.push_back(v(2, 0, 0, 0, 16'd100, 16'd48, 0, E));
    vq.push_back(v(2, 0, 0, 0, 16'd100, 16'd48, 0, E));
    vq.push_back(v(2, 0, 0, 0, 16'd100, 16'd48, 0, E));
    vq.push_back(v(2, 1, 0, 0, 16'd100, 16'd100, 0, E));
    vq.push_back(v(1, 1, 0, 0, 16'h200, 16'h200, 0, E));
    vq.push_back(v(3, 1, 0, 0, 16'h300, 16'h300, 0, E));
    vq.push_back(v(4, 1, 0, 0, 16'h400, 16'h400, 0, E));
    vq.push_back(v(5, 1, 0, 0, 16'h500, 16'h500, 0, E));
    vq.push_back(v(7, 1, 0, 0, 16'h777, 16'h500, 0, E));
    vq.push_back(v(2, 1, 0, 0, 16'hFFFE, 16'hFFFE, 0, E));
    vq.push_back(v(0, 1, 0, 0, 0, 16'h0000, 0, E));
`ifdef PC_RAS_EN
    vq.push_back(v(2, 1, 0, 0, 16'h10, 16'h10, 0, E));
    vq.push_back(v(2, 1, 1, 0, 16'h80, 16'h80, 16'h12, N));
    vq.push_back(v(2, 1, 1, 0, 16'hA0, 16'hA0, 16'h82, N));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h82, 16'h12, N));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h12, 0, E));
    vq.push_back(v(6, 1, 0, 0, 16'h300, 16'h300, 0, 4'b1001));
    vq.push_back(v(7, 1, 0, 1, 0, 16'h300, 0, E));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h302, 16'h302, N));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h304, 16'h304, N));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h306, 16'h306, N));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h308, 16'h308, 4'b0100));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h30A, 16'h30A, 4'b0110));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h30A, 16'h308, 4'b0010));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h308, 16'h306, 4'b0010));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h306, 16'h304, 4'b0010));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h304, 0, 4'b1010));
    vq.push_back(v(6, 1, 0, 0, 16'h777, 16'h777, 0, 4'b1011));
    vq.push_back(v(7, 1, 0, 1, 0, 16'h777, 0, E));
    vq.push_back(v(2, 1, 0, 0, 16'h4E, 16'h4E, 0, E));
    vq.push_back(v(2, 1, 1, 0, 16'h20, 16'h20, 16'h50, N));
    vq.push_back(v(6, 1, 1, 0, 16'h999, 16'h50, 16'h22, N));
    vq.push_back(v(6, 1, 0, 0, 16'h999, 16'h22, 0, E));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h24, 16'h24, N));
    vq.push_back(v(6, 1, 0, 1, 16'h999, 16'h24, 0, E));
    vq.push_back(v(0, 0, 1, 0, 0, 16'h24, 0, E));
    vq.push_back(v(2, 1, 1, 0, 16'h1234, 16'h1234, 16'h26, N));
`else
    vq.push_back(v(6, 1, 1, 0, 16'h300, 16'h300, 0, E));
    vq.push_back(v(0, 1, 1, 0, 0, 16'h302, 0, E));
    vq.push_back(v(6, 1, 0, 1, 16'h123, 16'h123, 0, E));
    vq.push_back(v(2, 1, 1, 0, 16'h1234, 16'h1234, 0, E));
`endif
    #2;
    chkAll("reset", 16'h0, 16'h0, E);
    #10 reset_n = 1'b1;
    foreach (vq[i]) begin
      apply(vq[i]);
      chkAll($sformatf("v%0d", i), vq[i].expPc, vq[i].expTop, vq[i].expFl);
    end
    #2 reset_n = 1'b0;
    #1 chkAll("asyncRst", 16'h0, 16'h0, E);
    apply(v(2, 1, 1, 0, 16'h3456, 16'h0, 16'h0, E));
    chkAll("heldRst", 16'h0, 16'h0, E);
    reset_n = 1'b1;
    apply(v(0, 1, 0, 0, 0, 16'h2, 16'h0, E));
    chkAll("afterRst", 16'h2, 16'h0, E);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
